// File: rtl/mac_unit.sv
// Signed multiply-accumulate stage: biased dot product over a term stream,
// one saturated OUT_W-bit result per vector, two-cycle latency, no backpressure.
module mac_unit #(
    parameter int unsigned IN_W      = 8,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned OUT_W     = 16,
    parameter int unsigned SHIFT     = 0,
    parameter int unsigned MAX_TERMS = 256
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 clear,
    input  logic [IN_W-1:0]                      act_in,
    input  logic [IN_W-1:0]                      wgt_in,
    input  logic [OUT_W-1:0]                     bias_in,
    input  logic                                 valid_in,
    input  logic                                 last_in,
    output logic [OUT_W-1:0]                     mac_out,
    output logic                                 valid_out,
    output logic                                 sat_out,
    output logic [$clog2(MAX_TERMS+1)-1:0]       term_count,
    output logic                                 overflow_err
);

    localparam int unsigned P_W   = 2 * IN_W;
    localparam int unsigned CNT_W = $clog2(MAX_TERMS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TERMS);

    // Saturation bounds of the OUT_W result, expressed at accumulator width
    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic accept;
    logic first;

    // Stage P registers
    logic                    p_valid;
    logic                    p_last;
    logic                    p_first;
    logic signed [P_W-1:0]   prod;
    logic [OUT_W-1:0]        p_bias;

    // Stage A
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] scaled;
    logic [OUT_W-1:0]        res;
    logic                    res_sat;
    logic                    finalize;

    logic signed [P_W-1:0]   act_x;
    logic signed [P_W-1:0]   wgt_x;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and term acceptance; clear wins over valid_in
    always_comb begin
        state_next = state;
        accept     = valid_in & ~clear;
        first      = accept & (state == IDLE);
        if (clear) begin
            state_next = IDLE;
        end else if (valid_in) begin
            state_next = last_in ? IDLE : ACCUM;
        end
    end

    assign act_x = {{IN_W{act_in[IN_W-1]}}, act_in};
    assign wgt_x = {{IN_W{wgt_in[IN_W-1]}}, wgt_in};

    // Stage P: register the product and the term's framing bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_valid <= 1'b0;
            p_last  <= 1'b0;
            p_first <= 1'b0;
            prod    <= '0;
            p_bias  <= '0;
        end else begin
            p_valid <= accept;
            p_last  <= accept & last_in;
            p_first <= first;
            if (accept) begin
                prod <= act_x * wgt_x;
            end
            if (first) begin
                p_bias <= bias_in;
            end
        end
    end

    // Stage A: a first term seeds the sum with the pre-aligned bias
    always_comb begin
        bias_ext = {{(ACC_W-OUT_W){p_bias[OUT_W-1]}}, p_bias};
        prod_ext = {{(ACC_W-P_W){prod[P_W-1]}}, prod};
        acc_base = p_first ? (bias_ext <<< SHIFT) : acc;
        acc_next = acc_base + prod_ext;
        scaled   = acc_next >>> SHIFT;
        res      = scaled[OUT_W-1:0];
        res_sat  = 1'b0;
        if (scaled > SAT_HI) begin
            res     = OUT_MAX;
            res_sat = 1'b1;
        end else if (scaled < SAT_LO) begin
            res     = OUT_MIN;
            res_sat = 1'b1;
        end
    end

    assign finalize = p_valid & p_last & ~clear;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (p_valid && !clear) begin
            acc <= acc_next;
        end
    end

    // Result registers; mac_out and sat_out hold between results
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mac_out   <= '0;
            sat_out   <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= finalize;
            if (finalize) begin
                mac_out <= res;
                sat_out <= res_sat;
            end
        end
    end

    // Term counter saturates at MAX_TERMS; overflow is sticky until clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            term_count   <= '0;
            overflow_err <= 1'b0;
        end else if (clear) begin
            term_count   <= '0;
            overflow_err <= 1'b0;
        end else if (accept) begin
            if (term_count == CNT_MAX) begin
                overflow_err <= 1'b1;
            end
            if (last_in) begin
                term_count <= '0;
            end else if (term_count != CNT_MAX) begin
                term_count <= term_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mac_unit.sv
// Directed bench for mac_unit: default instance plus a MAX_TERMS=4 instance
// sharing the same input stream.
module tb_mac_unit;

    logic        clk;
    logic        reset_n;
    logic        clear;
    logic [7:0]  act;
    logic [7:0]  wgt;
    logic [15:0] bias;
    logic        valid;
    logic        last;

    logic [15:0] mac_out;
    logic        valid_out;
    logic        sat_out;
    logic [8:0]  term_count;
    logic        overflow_err;

    logic [15:0] s_mac_out;
    logic        s_valid_out;
    logic        s_sat_out;
    logic [2:0]  s_term_count;
    logic        s_overflow_err;

    int total;
    int bad;

    mac_unit u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .act_in       (act),
        .wgt_in       (wgt),
        .bias_in      (bias),
        .valid_in     (valid),
        .last_in      (last),
        .mac_out      (mac_out),
        .valid_out    (valid_out),
        .sat_out      (sat_out),
        .term_count   (term_count),
        .overflow_err (overflow_err)
    );

    mac_unit #(.MAX_TERMS(4)) u_small (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .act_in       (act),
        .wgt_in       (wgt),
        .bias_in      (bias),
        .valid_in     (valid),
        .last_in      (last),
        .mac_out      (s_mac_out),
        .valid_out    (s_valid_out),
        .sat_out      (s_sat_out),
        .term_count   (s_term_count),
        .overflow_err (s_overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one term for one cycle; returns at the following negedge
    task automatic term(input int a, input int w, input int b, input logic l);
        act   = 8'(a);
        wgt   = 8'(w);
        bias  = 16'(b);
        valid = 1'b1;
        last  = l;
        @(negedge clk);
        valid = 1'b0;
        last  = 1'b0;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        clear   = 1'b0;
        act     = '0;
        wgt     = '0;
        bias    = '0;
        valid   = 1'b0;
        last    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mac",   32'(mac_out), 32'h0);
        check("rst_valid", 32'(valid_out), 32'h0);
        check("rst_sat",   32'(sat_out), 32'h0);
        check("rst_cnt",   32'(term_count), 32'h0);
        check("rst_ovf",   32'(overflow_err), 32'h0);
        check("rst_s_cnt", 32'(s_term_count), 32'h0);
        reset_n = 1'b1;
        idle(1);

        // Basic dot product: 12 - 10 - 7 = -5
        term(3, 4, 0, 1'b0);
        check("basic_cnt1", 32'(term_count), 32'd1);
        term(-2, 5, 0, 1'b0);
        check("basic_cnt2", 32'(term_count), 32'd2);
        term(7, -1, 0, 1'b1);
        check("basic_cnt0", 32'(term_count), 32'd0);
        check("basic_lat",  32'(valid_out), 32'h0);
        idle(1);
        check("basic_vld",  32'(valid_out), 32'h1);
        check("basic_mac",  32'(mac_out), 32'hFFFB);
        check("basic_sat",  32'(sat_out), 32'h0);
        idle(1);
        check("basic_pulse", 32'(valid_out), 32'h0);
        check("basic_hold",  32'(mac_out), 32'hFFFB);

        // Single-term vector A then vector B back-to-back
        term(10, 10, 100, 1'b1);
        term(1, 1, -5, 1'b0);
        check("a_vld", 32'(valid_out), 32'h1);
        check("a_mac", 32'(mac_out), 32'h00C8);
        term(2, 2, 0, 1'b1);
        check("a_pulse", 32'(valid_out), 32'h0);
        idle(1);
        check("b_vld", 32'(valid_out), 32'h1);
        check("b_mac", 32'(mac_out), 32'h0000);
        idle(1);
        check("b_pulse", 32'(valid_out), 32'h0);

        // Positive saturation: 4 * 16129 = 64516
        for (int i = 0; i < 4; i++) term(127, 127, 0, i == 3);
        idle(1);
        check("satp_vld", 32'(valid_out), 32'h1);
        check("satp_mac", 32'(mac_out), 32'h7FFF);
        check("satp_sat", 32'(sat_out), 32'h1);
        idle(1);

        // Negative saturation: 3 * -16256 = -48768
        for (int i = 0; i < 3; i++) term(-128, 127, 0, i == 2);
        idle(1);
        check("satn_vld", 32'(valid_out), 32'h1);
        check("satn_mac", 32'(mac_out), 32'h8000);
        check("satn_sat", 32'(sat_out), 32'h1);
        idle(1);
        check("satn_hold", 32'(sat_out), 32'h1);

        // Idle gaps inside a vector: 6 + 20 = 26
        term(2, 3, 0, 1'b0);
        idle(3);
        check("gap_cnt", 32'(term_count), 32'd1);
        check("gap_quiet", 32'(valid_out), 32'h0);
        term(4, 5, 0, 1'b1);
        idle(1);
        check("gap_vld", 32'(valid_out), 32'h1);
        check("gap_mac", 32'(mac_out), 32'h001A);
        check("gap_sat", 32'(sat_out), 32'h0);
        idle(1);

        // Clear aborts the open vector and drops a concurrent last term
        term(1, 2, 0, 1'b0);
        term(3, 4, 0, 1'b0);
        check("clr_cnt_pre", 32'(term_count), 32'd2);
        clear = 1'b1;
        term(9, 9, 0, 1'b1);
        clear = 1'b0;
        check("clr_cnt", 32'(term_count), 32'd0);
        check("clr_vld0", 32'(valid_out), 32'h0);
        idle(1);
        check("clr_vld1", 32'(valid_out), 32'h0);
        check("clr_mac_hold", 32'(mac_out), 32'h001A);
        term(1, 1, 0, 1'b1);
        idle(1);
        check("clr_fresh_vld", 32'(valid_out), 32'h1);
        check("clr_fresh_mac", 32'(mac_out), 32'h0001);
        idle(1);

        // Asynchronous reset mid-vector
        term(5, 5, 0, 1'b0);
        term(5, 5, 0, 1'b0);
        check("mid_cnt", 32'(term_count), 32'd2);
        reset_n = 1'b0;
        #1;
        check("mid_rst_mac", 32'(mac_out), 32'h0);
        check("mid_rst_cnt", 32'(term_count), 32'h0);
        check("mid_rst_vld", 32'(valid_out), 32'h0);
        check("mid_rst_sat", 32'(sat_out), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(1);
        check("mid_quiet", 32'(valid_out), 32'h0);
        term(6, 7, 0, 1'b1);
        idle(1);
        check("mid_vld", 32'(valid_out), 32'h1);
        check("mid_mac", 32'(mac_out), 32'h002A);
        idle(1);

        // Overflow on the MAX_TERMS=4 instance with a 5-term vector
        for (int i = 0; i < 4; i++) term(1, 1, 0, 1'b0);
        check("ovf_s_cnt4", 32'(s_term_count), 32'd4);
        check("ovf_s_pre",  32'(s_overflow_err), 32'h0);
        term(1, 1, 0, 1'b1);
        check("ovf_s_set",  32'(s_overflow_err), 32'h1);
        check("ovf_s_cnt0", 32'(s_term_count), 32'd0);
        check("ovf_big",    32'(overflow_err), 32'h0);
        idle(1);
        check("ovf_s_vld",  32'(s_valid_out), 32'h1);
        check("ovf_s_mac",  32'(s_mac_out), 32'h0005);
        check("ovf_big_mac", 32'(mac_out), 32'h0005);
        idle(2);
        check("ovf_sticky", 32'(s_overflow_err), 32'h1);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        check("ovf_clr", 32'(s_overflow_err), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
